// File: rtl/enemy_proj_handler.sv
`default_nettype none
// ============================================================================
//  Module   : enemy_proj_handler
//  Purpose  : Tracks up to three enemy projectiles that travel down the screen.
//             It spawns a projectile centred under the enemy sprite when a fire
//             request is accepted. Each projectile moves PROJ_STEP pixels per
//             pulse_projSpeed tick. A projectile is retired when it reaches the
//             bottom of the screen or when the collision unit reports a hit.
//  Ports    : clk, rst (async, active-low)
//             pulse_projSpeed - movement tick
//             fire            - enemy fire request
//             projHit / collidedProj - hit report (index 1..3, 0 = none)
//             enemyX/Y/W/H    - enemy sprite geometry
//             fireAck         - one-cycle pulse on an accepted fire request
//             projActive      - per-slot in-flight flags
//             projNX/projNY   - slot positions (0 while idle)
//  Revision : 1.0 - initial release
// ============================================================================
module enemy_proj_handler #(
  parameter int SCREEN_H  = 480,
  parameter int PROJ_W    = 4,
  parameter int PROJ_STEP = 4,
  parameter int COOLDOWN  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pulse_projSpeed,
  input  logic       fire,
  input  logic       projHit,
  input  logic [1:0] collidedProj,
  input  logic [9:0] enemyX,
  input  logic [8:0] enemyY,
  input  logic [9:0] enemyW,
  input  logic [8:0] enemyH,
  output logic       fireAck,
  output logic [2:0] projActive,
  output logic [9:0] proj1X,
  output logic [9:0] proj2X,
  output logic [9:0] proj3X,
  output logic [8:0] proj1Y,
  output logic [8:0] proj2Y,
  output logic [8:0] proj3Y
);

  localparam int CD_W = $clog2(COOLDOWN + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    FLYING = 1'b1
  } slot_state_t;

  logic [CD_W-1:0] cd_q;
  logic [2:0]      idle_vec;
  logic [1:0]      free_idx;
  logic            free_found;
  logic            spawn;
  logic [9:0]      spawn_x;
  logic [8:0]      spawn_y;
  logic [9:0]      x_all [3];
  logic [8:0]      y_all [3];

  // Lowest-index idle slot, judged on the registered state only so a slot
  // that is freed this cycle cannot be reused until the next one.
  always_comb begin
    free_found = 1'b0;
    free_idx   = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      if (idle_vec[i]) begin
        free_found = 1'b1;
        free_idx   = 2'(i);
      end
    end
  end

  assign spawn = fire && (cd_q == '0) && free_found;

  // Spawn position evaluated in 11 bits, then truncated to the port width.
  assign spawn_x = 10'(({1'b0, enemyX} + ({1'b0, enemyW} >> 1)) - 11'(PROJ_W >> 1));
  assign spawn_y = 9'({2'b00, enemyY} + {2'b00, enemyH});

  generate
    for (genvar i = 0; i < 3; i++) begin : g_slot
      slot_state_t state_q, state_d;
      logic [9:0]  x_q, x_d;
      logic [8:0]  y_q, y_d;
      logic [9:0]  y_adv;
      logic        hit;

      assign hit   = projHit && (collidedProj == 2'(i + 1));
      assign y_adv = {1'b0, y_q} + 10'(PROJ_STEP);

      always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
          IDLE: begin
            if (spawn && (free_idx == 2'(i))) begin
              state_d = FLYING;
              x_d     = spawn_x;
              y_d     = spawn_y;
            end
          end
          FLYING: begin
            // A hit takes precedence over movement in the same cycle.
            if (hit) begin
              state_d = IDLE;
              x_d     = '0;
              y_d     = '0;
            end else if (pulse_projSpeed) begin
              if (y_adv >= 10'(SCREEN_H)) begin
                state_d = IDLE;
                x_d     = '0;
                y_d     = '0;
              end else begin
                y_d = y_adv[8:0];
              end
            end
          end
          default: begin
            state_d = IDLE;
            x_d     = '0;
            y_d     = '0;
          end
        endcase
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state_q <= IDLE;
          x_q     <= '0;
          y_q     <= '0;
        end else begin
          state_q <= state_d;
          x_q     <= x_d;
          y_q     <= y_d;
        end
      end

      assign idle_vec[i]   = (state_q == IDLE);
      assign projActive[i] = (state_q == FLYING);
      assign x_all[i]      = x_q;
      assign y_all[i]      = y_q;
    end
  endgenerate

  // A spawn reloads the cooldown and overrides any same-cycle decrement.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cd_q    <= '0;
      fireAck <= 1'b0;
    end else begin
      fireAck <= spawn;
      if (spawn) begin
        cd_q <= CD_W'(COOLDOWN);
      end else if (pulse_projSpeed && (cd_q != '0)) begin
        cd_q <= cd_q - 1'b1;
      end
    end
  end

  assign proj1X = x_all[0];
  assign proj2X = x_all[1];
  assign proj3X = x_all[2];
  assign proj1Y = y_all[0];
  assign proj2Y = y_all[1];
  assign proj3Y = y_all[2];

endmodule
`default_nettype wire
